weighted_max_finder: RTL and testbench
======================================

Name: weighted_max_finder

Overview:
- Pipelined, fully parameterised arg-max (or arg-min) finder over N_CH channels. Each channel carries WIDTH entries of WEIGHT bits.
- Sits downstream of the segment/SSG input ports. Picks the best-weighted entry across all channels and reports its value and flat index at a fixed, parameter-derived latency.
- Accepts a new input vector every cycle (throughput 1).
- Adds what the previous two-port block lacked: arbitrary channel count, per-cycle threshold qualification, min/max mode, a valid pipeline, and configurable register density.

Parameters:
- WEIGHT, 5: bit width of each entry value.
- WIDTH, 2: entries per channel.
- N_CH, 2: number of input channels. N_IN = N_CH*WIDTH; N_IN >= 2 required, else elaboration error.
- REG_EVERY, 1: comparator tree levels between pipeline registers (1..LEVELS).
- FIND_MIN, 0: 0 selects the largest value, 1 selects the smallest.
- IDX_W, $clog2(N_IN): width of the reported index (derived; do not override).
- LEVELS, $clog2(N_IN): comparator tree depth (derived).
- LATENCY, 1 + ceil(LEVELS/REG_EVERY): valid_i to valid_o latency in cycles (derived; exported for users).

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- valid_i, input, 1: qualifies data_i and thresh_i this cycle.
- thresh_i, input, WEIGHT: qualification threshold, sampled together with data_i.
- data_i, input, [WEIGHT-1:0] x [N_IN-1:0] unpacked: flat index = ch*WIDTH + entry.
- valid_o, output, 1: result valid, exactly LATENCY cycles after valid_i.
- found_o, output, 1: at least one entry qualified.
- best_o, output, WEIGHT: winning value.
- best_idx_o, output, IDX_W: flat index of the winner.

Behaviour:
- Reset, synchronous, active-high, sampled on the clk rising edge:
  - Clears every valid stage and all outputs to 0.
  - In-flight items are dropped; no stale valid_o after reset is released.
  - First valid_o can appear LATENCY cycles after the first valid_i seen with reset low.
- Stage 0, input register:
  - Captures data_i, thresh_i and valid_i.
  - Builds one candidate per entry: {q, val, idx}.
  - q = (val >= thresh) when FIND_MIN=0; q = (val <= thresh) when FIND_MIN=1.
- Comparator tree:
  - Binary tree of select nodes. The left input is always the lower index.
  - Odd count at any level: the unpaired candidate passes through unchanged.
  - A pipeline register follows every REG_EVERY levels. The final level is always registered.
- Node rule, in priority order:
  - Only one input qualified: pick the qualified one.
  - Neither qualified: pick left, with q=0.
  - Both qualified: pick the strictly better value (greater, or lesser when FIND_MIN).
  - Equal values: pick left, so the lowest flat index wins ties.
  - Comparison is unsigned, full WEIGHT width. No arithmetic widening.
- Outputs, registered:
  - valid_o mirrors the valid pipeline.
  - When valid_o=1: found_o = root q; best_o and best_idx_o come from the root.
  - If root q=0: best_o=0 and best_idx_o=0.
  - When valid_o=0: found_o, best_o and best_idx_o are forced to 0.
- Data registers advance every cycle; there is no stall or backpressure. Back-to-back valid_i produce back-to-back valid_o in order.
- Boundary conditions:
  - thresh_i=0 with FIND_MIN=0: every entry qualifies.
  - thresh_i=all-ones with FIND_MIN=1: every entry qualifies.
  - All values equal: index 0 wins.
  - N_IN not a power of two: handled by pass-through; best_idx_o never exceeds N_IN-1.
  - valid_i=0 cycles: bubbles propagate as valid_o=0 with zeroed outputs.

Decomposition:
- Shared package wmf_pkg holds:
  - Function clog2_ceil_div(a,b) for latency derivation.
  - Parameterised candidate struct type {q, val[WEIGHT], idx[IDX_W]}.
  - Function better(a,b,find_min) implementing the node rule.
- Sub-module wmf_sel_node: combinational two-candidate select, instantiated per tree node.
- Top level owns stage 0, the generate-built tree, register insertion and output gating.

Test Plan:
- Defaults (N_CH=2, WIDTH=2, LATENCY=3), one pulse: data {idx0=3, 1=17, 2=9, 3=17}, thresh=0, valid_i pulse at cycle t -> valid_o=1 at t+3 only; found=1, best=17, idx=1 (tie to lower index).
- Threshold filtering: data {4,6,2,5}, thresh=7 -> found=0, best=0, idx=0. Same data with thresh=5 -> found=1, best=6, idx=1.
- FIND_MIN=1, N_CH=3, WIDTH=1 (N_IN=3, odd pass-through, LATENCY=3): data {8,2,2}, thresh=31 -> best=2, idx=1. Data {8,9,1} -> best=1, idx=2.
- Streaming: 20 consecutive random valid_i cycles, then 3 bubbles, then 5 more -> outputs match the scoreboard in order at fixed LATENCY; bubbles give valid_o=0 with zeroed outputs.
- Reset mid-flight: valid_i at t and t+1, reset high at t+2 for 1 cycle -> no valid_o at t+3/t+4; all outputs 0 from t+3. A fresh valid_i at t+3 yields a correct result at t+6.
- REG_EVERY sweep: N_CH=4, WIDTH=4 (LEVELS=4) with REG_EVERY=1,2,4 -> measured LATENCY of 5, 3, 2 respectively; results identical to a reference arg-max model.

Source files
------------

// File: rtl/wmf_pkg.sv
// Shared helpers for the weighted max/min finder: latency math and the node rule.
package wmf_pkg;

    // Widest entry value the node rule handles; narrower values are zero-extended.
    localparam int unsigned MAX_WEIGHT = 32;

    // Ceiling of a/b, used to count pipeline registers along the tree.
    function automatic int unsigned clog2_ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Number of candidates alive at tree level lvl (odd counts round up).
    function automatic int unsigned level_count(input int unsigned n, input int unsigned lvl);
        return (n + (32'd1 << lvl) - 1) >> lvl;
    endfunction

    // Returns 1 when candidate b (higher index) must replace candidate a.
    // Ties and the neither-qualified case keep a, so the lowest index wins.
    function automatic logic better(input logic                  a_q,
                                    input logic [MAX_WEIGHT-1:0] a_val,
                                    input logic                  b_q,
                                    input logic [MAX_WEIGHT-1:0] b_val,
                                    input logic                  find_min);
        if (!b_q) return 1'b0;
        if (!a_q) return 1'b1;
        return find_min ? (b_val < a_val) : (b_val > a_val);
    endfunction

endpackage

// File: rtl/wmf_sel_node.sv
// Two-candidate select node; candidate layout is {q, val, idx}, left is lower index.
module wmf_sel_node
    import wmf_pkg::*;
#(
    parameter int unsigned  WEIGHT   = 5,
    parameter int unsigned  IDX_W    = 2,
    parameter bit           FIND_MIN = 1'b0,
    localparam int unsigned CW       = 1 + WEIGHT + IDX_W
) (
    input  logic [CW-1:0] left,
    input  logic [CW-1:0] right,
    output logic [CW-1:0] sel_c
);

    logic take_right_c;

    // Apply the node rule and forward the winner unchanged.
    always_comb begin
        take_right_c = better(left[CW-1],  MAX_WEIGHT'(left[IDX_W +: WEIGHT]),
                              right[CW-1], MAX_WEIGHT'(right[IDX_W +: WEIGHT]),
                              FIND_MIN);
        sel_c = take_right_c ? right : left;
    end

endmodule

// File: rtl/weighted_max_finder.sv
// Pipelined arg-max / arg-min over N_CH*WIDTH entries with threshold qualification.
module weighted_max_finder
    import wmf_pkg::*;
#(
    parameter int unsigned WEIGHT    = 5,
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned REG_EVERY = 1,
    parameter bit          FIND_MIN  = 1'b0,
    parameter int unsigned IDX_W     = $clog2(N_CH * WIDTH),
    parameter int unsigned LEVELS    = $clog2(N_CH * WIDTH),
    parameter int unsigned LATENCY   = 1 + clog2_ceil_div(LEVELS, REG_EVERY)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [WEIGHT-1:0] thresh_i,
    input  logic [WEIGHT-1:0] data_i [N_CH*WIDTH-1:0],
    output logic              valid_o,
    output logic              found_o,
    output logic [WEIGHT-1:0] best_o,
    output logic [IDX_W-1:0]  best_idx_o
);

    localparam int unsigned N_IN = N_CH * WIDTH;

    typedef struct packed {
        logic              q;
        logic [WEIGHT-1:0] val;
        logic [IDX_W-1:0]  idx;
    } cand_t;

    if (N_IN < 2) begin : g_chk_nin
        $error("weighted_max_finder: N_CH*WIDTH must be at least 2");
    end
    if (REG_EVERY < 1 || REG_EVERY > LEVELS) begin : g_chk_reg
        $error("weighted_max_finder: REG_EVERY must be within 1..LEVELS");
    end
    if (WEIGHT > MAX_WEIGHT) begin : g_chk_w
        $error("weighted_max_finder: WEIGHT exceeds MAX_WEIGHT");
    end

    logic [WEIGHT-1:0] data_q [N_IN];
    logic [WEIGHT-1:0] thresh_q;
    logic              valid_q;

    // Candidate set per tree level; level 0 is built from the input register.
    cand_t cand [LEVELS+1][N_IN];
    logic  vld  [LEVELS+1];

    // Stage 0: capture the input vector, threshold and valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            thresh_q <= '0;
            for (int i = 0; i < N_IN; i++) data_q[i] <= '0;
        end else begin
            valid_q  <= valid_i;
            thresh_q <= thresh_i;
            for (int i = 0; i < N_IN; i++) data_q[i] <= data_i[i];
        end
    end

    assign vld[0] = valid_q;

    for (genvar i = 0; i < N_IN; i++) begin : g_cand
        assign cand[0][i] = '{
            q:   FIND_MIN ? (data_q[i] <= thresh_q) : (data_q[i] >= thresh_q),
            val: data_q[i],
            idx: IDX_W'(i)
        };
    end

    // Comparator tree; a register follows every REG_EVERY levels, except the
    // last level, whose register is the gated output register below.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned PREV = level_count(N_IN, l - 1);
        localparam int unsigned CNT  = level_count(N_IN, l);
        localparam bit          REG  = (l < LEVELS) && ((l % REG_EVERY) == 0);

        cand_t node_c [CNT];

        for (genvar n = 0; n < CNT; n++) begin : g_node
            if (2 * n + 1 < PREV) begin : g_pair
                wmf_sel_node #(
                    .WEIGHT   (WEIGHT),
                    .IDX_W    (IDX_W),
                    .FIND_MIN (FIND_MIN)
                ) u_sel (
                    .left  (cand[l-1][2*n]),
                    .right (cand[l-1][2*n+1]),
                    .sel_c (node_c[n])
                );
            end else begin : g_pass
                assign node_c[n] = cand[l-1][2*n];
            end
        end

        if (REG) begin : g_reg
            cand_t pipe_q [CNT];
            logic  v_q;

            // Pipeline register between tree segments.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= 1'b0;
                    for (int i = 0; i < CNT; i++) pipe_q[i] <= '0;
                end else begin
                    v_q <= vld[l-1];
                    for (int i = 0; i < CNT; i++) pipe_q[i] <= node_c[i];
                end
            end

            for (genvar n = 0; n < CNT; n++) begin : g_out
                assign cand[l][n] = pipe_q[n];
            end
            assign vld[l] = v_q;
        end else begin : g_comb
            for (genvar n = 0; n < CNT; n++) begin : g_out
                assign cand[l][n] = node_c[n];
            end
            assign vld[l] = vld[l-1];
        end

        for (genvar n = CNT; n < N_IN; n++) begin : g_unused
            assign cand[l][n] = '0;
        end
    end

    cand_t root_c;
    assign root_c = cand[LEVELS][0];

    // Output register: result fields are zero unless valid and qualified.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o    <= 1'b0;
            found_o    <= 1'b0;
            best_o     <= '0;
            best_idx_o <= '0;
        end else begin
            valid_o <= vld[LEVELS];
            found_o <= vld[LEVELS] & root_c.q;
            if (vld[LEVELS] && root_c.q) begin
                best_o     <= root_c.val;
                best_idx_o <= root_c.idx;
            end else begin
                best_o     <= '0;
                best_idx_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weighted_max_finder.sv
// Directed bench: default max finder, odd-count min finder, REG_EVERY sweep.
module tb_weighted_max_finder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    // Default configuration: N_CH=2, WIDTH=2, max, LATENCY=3
    logic       a_valid;
    logic [4:0] a_thresh;
    logic [4:0] a_data [3:0];
    logic       a_vo, a_fo;
    logic [4:0] a_bo;
    logic [1:0] a_io;

    weighted_max_finder #(.WEIGHT(5), .WIDTH(2), .N_CH(2), .REG_EVERY(1), .FIND_MIN(1'b0)) u_a (
        .clk(clk), .reset(reset), .valid_i(a_valid), .thresh_i(a_thresh), .data_i(a_data),
        .valid_o(a_vo), .found_o(a_fo), .best_o(a_bo), .best_idx_o(a_io));

    // Min finder: N_CH=3, WIDTH=1, odd pass-through, LATENCY=3
    logic       m_valid;
    logic [4:0] m_thresh;
    logic [4:0] m_data [2:0];
    logic       m_vo, m_fo;
    logic [4:0] m_bo;
    logic [1:0] m_io;

    weighted_max_finder #(.WEIGHT(5), .WIDTH(1), .N_CH(3), .REG_EVERY(1), .FIND_MIN(1'b1)) u_m (
        .clk(clk), .reset(reset), .valid_i(m_valid), .thresh_i(m_thresh), .data_i(m_data),
        .valid_o(m_vo), .found_o(m_fo), .best_o(m_bo), .best_idx_o(m_io));

    // Sweep: N_CH=4, WIDTH=4, LEVELS=4, REG_EVERY=1/2/4
    logic       s_valid;
    logic [4:0] s_thresh;
    logic [4:0] s_data [15:0];
    logic       s1_vo, s1_fo, s2_vo, s2_fo, s4_vo, s4_fo;
    logic [4:0] s1_bo, s2_bo, s4_bo;
    logic [3:0] s1_io, s2_io, s4_io;

    weighted_max_finder #(.WEIGHT(5), .WIDTH(4), .N_CH(4), .REG_EVERY(1), .FIND_MIN(1'b0)) u_s1 (
        .clk(clk), .reset(reset), .valid_i(s_valid), .thresh_i(s_thresh), .data_i(s_data),
        .valid_o(s1_vo), .found_o(s1_fo), .best_o(s1_bo), .best_idx_o(s1_io));
    weighted_max_finder #(.WEIGHT(5), .WIDTH(4), .N_CH(4), .REG_EVERY(2), .FIND_MIN(1'b0)) u_s2 (
        .clk(clk), .reset(reset), .valid_i(s_valid), .thresh_i(s_thresh), .data_i(s_data),
        .valid_o(s2_vo), .found_o(s2_fo), .best_o(s2_bo), .best_idx_o(s2_io));
    weighted_max_finder #(.WEIGHT(5), .WIDTH(4), .N_CH(4), .REG_EVERY(4), .FIND_MIN(1'b0)) u_s4 (
        .clk(clk), .reset(reset), .valid_i(s_valid), .thresh_i(s_thresh), .data_i(s_data),
        .valid_o(s4_vo), .found_o(s4_fo), .best_o(s4_bo), .best_idx_o(s4_io));

    typedef struct packed {
        logic       f;
        logic [4:0] b;
        logic [3:0] i;
    } res_t;

    typedef struct {
        bit         dut;     // 0: default max finder, 1: min finder
        logic [4:0] d [4];
        logic [4:0] th;
        logic       f;
        logic [4:0] b;
        logic [1:0] i;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sequential reference: first strictly better qualified entry wins.
    function automatic res_t model(input logic [4:0] d [16], input int n,
                                   input logic [4:0] th, input bit fmin);
        res_t r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            logic q;
            q = fmin ? (d[k] <= th) : (d[k] >= th);
            if (q && (!r.f || (fmin ? (d[k] < r.b) : (d[k] > r.b)))) begin
                r.f = 1'b1;
                r.b = d[k];
                r.i = 4'(k);
            end
        end
        return r;
    endfunction

    task automatic setv(input int k, input bit dut, input int d0, input int d1, input int d2,
                        input int d3, input int th, input int f, input int b, input int i);
        tbl[k].dut  = dut;
        tbl[k].d[0] = 5'(d0);
        tbl[k].d[1] = 5'(d1);
        tbl[k].d[2] = 5'(d2);
        tbl[k].d[3] = 5'(d3);
        tbl[k].th   = 5'(th);
        tbl[k].f    = 1'(f);
        tbl[k].b    = 5'(b);
        tbl[k].i    = 2'(i);
    endtask

    task automatic chk_a(input string name, input int v, input int f, input int b, input int i);
        chk({name, ".valid"}, int'(a_vo), v);
        chk({name, ".found"}, int'(a_fo), f);
        chk({name, ".best"},  int'(a_bo), b);
        chk({name, ".idx"},   int'(a_io), i);
    endtask

    logic [4:0] st_d  [28][4];
    logic [4:0] st_th [28];
    logic       st_v  [28];
    logic [4:0] tmp   [16];

    initial begin
        res_t e;
        int   vo, fo, bo, io;

        a_valid = 1'b0; a_thresh = '0;
        m_valid = 1'b0; m_thresh = '0;
        s_valid = 1'b0; s_thresh = '0;
        for (int k = 0; k < 4;  k++) a_data[k] = '0;
        for (int k = 0; k < 3;  k++) m_data[k] = '0;
        for (int k = 0; k < 16; k++) s_data[k] = '0;
        for (int k = 0; k < 16; k++) tmp[k] = '0;

        //    k dut  d0  d1  d2  d3  th  f   b  i
        setv( 0, 0,   3, 17,  9, 17,  0, 1, 17, 1);
        setv( 1, 0,   4,  6,  2,  5,  7, 0,  0, 0);
        setv( 2, 0,   4,  6,  2,  5,  5, 1,  6, 1);
        setv( 3, 0,   7,  7,  7,  7,  0, 1,  7, 0);
        setv( 4, 0,   0,  0,  0,  0,  0, 1,  0, 0);
        setv( 5, 0,  31, 30, 31,  2,  0, 1, 31, 0);
        setv( 6, 0,   1,  2,  3,  4,  4, 1,  4, 3);
        setv( 7, 1,   8,  2,  2,  0, 31, 1,  2, 1);
        setv( 8, 1,   8,  9,  1,  0, 31, 1,  1, 2);
        setv( 9, 1,   8,  9,  1,  0,  0, 0,  0, 0);
        setv(10, 1,   6,  3,  4,  0,  3, 1,  3, 1);

        // Reset state
        reset = 1'b1;
        tick(); tick(); tick();
        chk_a("reset.a", 0, 0, 0, 0);
        chk("reset.m.valid",  int'(m_vo),  0);
        chk("reset.s1.valid", int'(s1_vo), 0);
        chk("reset.s4.best",  int'(s4_bo), 0);
        reset = 1'b0;
        tick();
        chk("idle.a.valid", int'(a_vo), 0);

        // Table: single pulse, result exactly at LATENCY=3 and gone next cycle
        for (int k = 0; k < NV; k++) begin
            if (!tbl[k].dut) begin
                for (int j = 0; j < 4; j++) a_data[j] = tbl[k].d[j];
                a_thresh = tbl[k].th;
                a_valid  = 1'b1;
            end else begin
                for (int j = 0; j < 3; j++) m_data[j] = tbl[k].d[j];
                m_thresh = tbl[k].th;
                m_valid  = 1'b1;
            end
            tick();
            a_valid = 1'b0;
            m_valid = 1'b0;
            tick();
            vo = tbl[k].dut ? int'(m_vo) : int'(a_vo);
            chk($sformatf("tbl%0d.early_valid", k), vo, 0);
            tick();
            vo = tbl[k].dut ? int'(m_vo) : int'(a_vo);
            fo = tbl[k].dut ? int'(m_fo) : int'(a_fo);
            bo = tbl[k].dut ? int'(m_bo) : int'(a_bo);
            io = tbl[k].dut ? int'(m_io) : int'(a_io);
            chk($sformatf("tbl%0d.valid", k), vo, 1);
            chk($sformatf("tbl%0d.found", k), fo, int'(tbl[k].f));
            chk($sformatf("tbl%0d.best", k),  bo, int'(tbl[k].b));
            chk($sformatf("tbl%0d.idx", k),   io, int'(tbl[k].i));
            tick();
            vo = tbl[k].dut ? int'(m_vo) : int'(a_vo);
            chk($sformatf("tbl%0d.late_valid", k), vo, 0);
        end

        // Streaming: 20 valid, 3 bubbles, 5 valid, back to back
        for (int k = 0; k < 28; k++) begin
            st_v[k]  = !(k >= 20 && k < 23);
            st_th[k] = 5'($urandom_range(0, 20));
            for (int j = 0; j < 4; j++) st_d[k][j] = 5'($urandom_range(0, 31));
        end
        for (int k = 0; k < 31; k++) begin
            int jj;
            if (k < 28) begin
                a_valid  = st_v[k];
                a_thresh = st_th[k];
                for (int j = 0; j < 4; j++) a_data[j] = st_d[k][j];
            end else begin
                a_valid = 1'b0;
            end
            tick();
            jj = k + 1 - 3;
            e  = '0;
            if (jj >= 0 && jj < 28 && st_v[jj]) begin
                for (int j = 0; j < 4; j++) tmp[j] = st_d[jj][j];
                e = model(tmp, 4, st_th[jj], 1'b0);
                chk_a($sformatf("stream%0d", jj), 1, int'(e.f), int'(e.b), int'(e.i));
            end else begin
                chk_a($sformatf("bubble%0d", k), 0, 0, 0, 0);
            end
        end

        // Reset mid-flight: two items in flight are dropped
        for (int j = 0; j < 4; j++) a_data[j] = tbl[0].d[j];
        a_thresh = '0;
        a_valid  = 1'b1;
        tick();
        for (int j = 0; j < 4; j++) a_data[j] = 5'(j + 1);
        tick();
        a_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        chk_a("rst.t3", 0, 0, 0, 0);
        a_data[0] = 5'd9; a_data[1] = 5'd1; a_data[2] = 5'd30; a_data[3] = 5'd30;
        a_thresh  = 5'd10;
        a_valid   = 1'b1;
        tick();
        a_valid = 1'b0;
        chk_a("rst.t4", 0, 0, 0, 0);
        tick();
        chk_a("rst.t5", 0, 0, 0, 0);
        tick();
        chk_a("rst.t6", 1, 1, 30, 2);

        // REG_EVERY sweep: measured latency and result against the model
        for (int p = 0; p < 6; p++) begin
            int   l1, l2, l4;
            res_t r1, r2, r4;
            for (int k = 0; k < 16; k++) s_data[k] = 5'($urandom_range(0, 20));
            s_thresh = 5'($urandom_range(0, 15));
            if (p == 1) begin
                for (int k = 0; k < 16; k++) s_data[k] = 5'd12;
                s_thresh = 5'd0;
            end
            if (p == 2) begin
                s_data[9] = 5'd31; s_data[14] = 5'd31; s_thresh = 5'd31;
            end
            if (p == 3) s_thresh = 5'd25;
            if (p == 4) begin
                for (int k = 0; k < 16; k++) s_data[k] = 5'(k + 10);
                s_thresh = 5'd0;
            end
            if (p == 5) s_thresh = 5'd0;
            for (int k = 0; k < 16; k++) tmp[k] = s_data[k];
            e  = model(tmp, 16, s_thresh, 1'b0);
            l1 = 0; l2 = 0; l4 = 0;
            r1 = '0; r2 = '0; r4 = '0;
            s_valid = 1'b1;
            for (int c = 1; c <= 12; c++) begin
                tick();
                s_valid = 1'b0;
                if (s1_vo && l1 == 0) begin l1 = c; r1 = {s1_fo, s1_bo, s1_io}; end
                if (s2_vo && l2 == 0) begin l2 = c; r2 = {s2_fo, s2_bo, s2_io}; end
                if (s4_vo && l4 == 0) begin l4 = c; r4 = {s4_fo, s4_bo, s4_io}; end
            end
            chk($sformatf("sweep%0d.lat_re1", p), l1, 5);
            chk($sformatf("sweep%0d.lat_re2", p), l2, 3);
            chk($sformatf("sweep%0d.lat_re4", p), l4, 2);
            chk($sformatf("sweep%0d.res_re1", p), int'(r1), int'(e));
            chk($sformatf("sweep%0d.res_re2", p), int'(r2), int'(e));
            chk($sformatf("sweep%0d.res_re4", p), int'(r4), int'(e));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
